// File: rtl/cacheline_adapter_mc.sv
// Multi-channel cacheline <-> burst-memory adapter: one transaction in flight, lines split into beats.
// Build option CLA_RR_ARB_EN selects round-robin arbitration; otherwise the lowest requesting channel wins.
module cacheline_adapter_mc #(
  parameter int NUM_CH  = 3,
  parameter int LINE_W  = 256,
  parameter int BURST_W = 64,
  parameter int ADDR_W  = 32
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic [NUM_CH*ADDR_W-1:0]   ch_addr,
  input  logic [NUM_CH-1:0]          ch_read,
  input  logic [NUM_CH-1:0]          ch_write,
  input  logic [NUM_CH*LINE_W-1:0]   ch_wdata,
  output logic [LINE_W-1:0]          ch_rdata,
  output logic [NUM_CH-1:0]          ch_resp,
  output logic [ADDR_W-1:0]          bmem_addr,
  output logic                       bmem_read,
  output logic                       bmem_write,
  output logic [BURST_W-1:0]         bmem_wdata,
  input  logic                       bmem_ready,
  input  logic [ADDR_W-1:0]          bmem_raddr,
  input  logic [BURST_W-1:0]         bmem_rdata,
  input  logic                       bmem_rvalid
);

  localparam int BEATS = LINE_W / BURST_W;
  localparam int CNT_W = $clog2(BEATS);
  localparam int PTR_W = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
`ifdef CLA_RR_ARB_EN
  localparam int RR_EN = 1;
`else
  localparam int RR_EN = 0;
`endif

  typedef enum logic [2:0] {IDLE, RD_REQ, RD_DATA, WR_DATA, RESP} state_t;

  state_t              r_state;
  logic [CNT_W-1:0]    r_cnt;
  logic [PTR_W-1:0]    r_gnt;
  logic [PTR_W-1:0]    r_ptr;
  logic [ADDR_W-1:0]   r_addr;
  logic [LINE_W-1:0]   r_wline;
  logic [LINE_W-1:0]   r_rline;
  logic [LINE_W-1:0]   r_rdata;

  logic [NUM_CH-1:0]   w_req;
  logic                w_any;
  logic [PTR_W-1:0]    w_gnt;
  logic                w_last;
  logic [LINE_W-1:0]   w_rline_nx;
  logic                w_unused_raddr;

  assign w_req          = ch_read | ch_write;
  assign w_last         = (r_cnt == CNT_W'(BEATS - 1));
  assign w_unused_raddr = ^bmem_raddr;

  // Search starts at the pointer in round-robin mode, at channel 0 otherwise.
  always_comb begin
    w_any = 1'b0;
    w_gnt = '0;
    for (int k = 0; k < NUM_CH; k++) begin
      if (!w_any && w_req[(RR_EN * int'(r_ptr) + k) % NUM_CH]) begin
        w_any = 1'b1;
        w_gnt = PTR_W'((RR_EN * int'(r_ptr) + k) % NUM_CH);
      end
    end
  end

  always_comb begin
    w_rline_nx = r_rline;
    w_rline_nx[int'(r_cnt)*BURST_W +: BURST_W] = bmem_rdata;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= IDLE;
      r_cnt   <= '0;
      r_gnt   <= '0;
      r_ptr   <= '0;
      r_addr  <= '0;
      r_rdata <= '0;
    end else begin
      case (r_state)
        IDLE: begin
          if (w_any) begin
            r_gnt   <= w_gnt;
            r_addr  <= ch_addr[int'(w_gnt)*ADDR_W +: ADDR_W];
            r_cnt   <= '0;
            r_ptr   <= (w_gnt == PTR_W'(NUM_CH - 1)) ? '0 : w_gnt + 1'b1;
            r_state <= ch_write[w_gnt] ? WR_DATA : RD_REQ;
          end
        end
        RD_REQ: begin
          if (bmem_ready) r_state <= RD_DATA;
        end
        RD_DATA: begin
          if (bmem_rvalid) begin
            r_cnt <= w_last ? '0 : r_cnt + 1'b1;
            if (w_last) begin
              r_rdata <= w_rline_nx;
              r_state <= RESP;
            end
          end
        end
        WR_DATA: begin
          if (bmem_ready) begin
            r_cnt <= w_last ? '0 : r_cnt + 1'b1;
            if (w_last) r_state <= RESP;
          end
        end
        RESP:    r_state <= IDLE;
        default: r_state <= IDLE;
      endcase
    end
  end

  // Line buffers carry data only; the control state decides when they are meaningful.
  always_ff @(posedge clk) begin
    if (r_state == IDLE && w_any)
      r_wline <= ch_wdata[int'(w_gnt)*LINE_W +: LINE_W];
    if (r_state == RD_DATA && bmem_rvalid)
      r_rline <= w_rline_nx;
  end

  assign bmem_read  = (r_state == RD_REQ);
  assign bmem_write = (r_state == WR_DATA);
  assign bmem_wdata = bmem_write ? r_wline[int'(r_cnt)*BURST_W +: BURST_W] : '0;
  assign bmem_addr  = r_addr;
  assign ch_rdata   = r_rdata;
  assign ch_resp    = (r_state == RESP) ? (NUM_CH'(1) << r_gnt) : '0;

endmodule

// File: tb/tb_cacheline_adapter_mc.sv
// Directed self-checking bench for cacheline_adapter_mc (default parameters; honours CLA_RR_ARB_EN).
module tb_cacheline_adapter_mc;
  localparam int NUM_CH  = 3;
  localparam int LINE_W  = 256;
  localparam int BURST_W = 64;
  localparam int ADDR_W  = 32;
  localparam int BEATS   = 4;

  logic                     clk = 1'b0;
  logic                     rst;
  logic [NUM_CH*ADDR_W-1:0] ch_addr;
  logic [NUM_CH-1:0]        ch_read;
  logic [NUM_CH-1:0]        ch_write;
  logic [NUM_CH*LINE_W-1:0] ch_wdata;
  logic [LINE_W-1:0]        ch_rdata;
  logic [NUM_CH-1:0]        ch_resp;
  logic [ADDR_W-1:0]        bmem_addr;
  logic                     bmem_read;
  logic                     bmem_write;
  logic [BURST_W-1:0]       bmem_wdata;
  logic                     bmem_ready;
  logic [ADDR_W-1:0]        bmem_raddr;
  logic [BURST_W-1:0]       bmem_rdata;
  logic                     bmem_rvalid;

  int n_cmp = 0;
  int n_err = 0;

  cacheline_adapter_mc #(
    .NUM_CH(NUM_CH), .LINE_W(LINE_W), .BURST_W(BURST_W), .ADDR_W(ADDR_W)
  ) dut (
    .clk(clk), .rst(rst),
    .ch_addr(ch_addr), .ch_read(ch_read), .ch_write(ch_write), .ch_wdata(ch_wdata),
    .ch_rdata(ch_rdata), .ch_resp(ch_resp),
    .bmem_addr(bmem_addr), .bmem_read(bmem_read), .bmem_write(bmem_write),
    .bmem_wdata(bmem_wdata), .bmem_ready(bmem_ready), .bmem_raddr(bmem_raddr),
    .bmem_rdata(bmem_rdata), .bmem_rvalid(bmem_rvalid)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL timeout got=running exp=finished");
    $fatal(1, "timeout");
  end

  task automatic chk(input string tag, input logic [LINE_W-1:0] got, input logic [LINE_W-1:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Caller raises the request; first tick is the grant edge.
  task automatic wr_txn(input logic [LINE_W-1:0] line, input logic [ADDR_W-1:0] addr,
                        input logic [NUM_CH-1:0] exp_resp, input int stall_at, input int nstall);
    bmem_ready = 1'b1;
    tick();
    for (int b = 0; b < BEATS; b++) begin
      if (b == stall_at) begin
        bmem_ready = 1'b0;
        for (int s = 0; s < nstall; s++) begin
          chk("wr_hold_vld", bmem_write, 1);
          chk("wr_hold_beat", bmem_wdata, line[b*BURST_W +: BURST_W]);
          tick();
        end
        bmem_ready = 1'b1;
      end
      chk("wr_vld", bmem_write, 1);
      chk("wr_beat", bmem_wdata, line[b*BURST_W +: BURST_W]);
      chk("wr_addr", bmem_addr, addr);
      chk("wr_noread", bmem_read, 0);
      chk("wr_noresp", ch_resp, 0);
      tick();
    end
    chk("wr_resp", ch_resp, exp_resp);
    chk("wr_done_vld", bmem_write, 0);
    tick();
    chk("wr_resp_once", ch_resp, 0);
  endtask

  task automatic rd_txn(input logic [BURST_W-1:0] base, input logic [ADDR_W-1:0] addr,
                        input logic [NUM_CH-1:0] exp_resp, input int stall_n,
                        input int gap_after, input int gap_n);
    logic [LINE_W-1:0] exp_line;
    exp_line   = '0;
    bmem_ready = (stall_n == 0);
    tick();
    for (int s = 0; s < stall_n; s++) begin
      chk("rd_hold_cmd", bmem_read, 1);
      chk("rd_hold_addr", bmem_addr, addr);
      tick();
    end
    bmem_ready = 1'b1;
    chk("rd_cmd", bmem_read, 1);
    chk("rd_addr", bmem_addr, addr);
    chk("rd_nowrite", bmem_write, 0);
    tick();
    chk("rd_cmd_pulse", bmem_read, 0);
    for (int i = 0; i < BEATS; i++) begin
      bmem_rvalid = 1'b1;
      bmem_rdata  = base + BURST_W'(i);
      exp_line[i*BURST_W +: BURST_W] = base + BURST_W'(i);
      chk("rd_noresp", ch_resp, 0);
      tick();
      bmem_rvalid = 1'b0;
      if (i == gap_after) begin
        for (int g = 0; g < gap_n; g++) begin
          chk("rd_gap_noresp", ch_resp, 0);
          tick();
        end
      end
    end
    chk("rd_resp", ch_resp, exp_resp);
    chk("rd_line", ch_rdata, exp_line);
    tick();
    chk("rd_resp_once", ch_resp, 0);
    chk("rd_line_hold", ch_rdata, exp_line);
  endtask

  initial begin
    logic [LINE_W-1:0]   line;
    logic [NUM_CH-1:0]   exp_resp;
    logic [ADDR_W-1:0]   exp_addr;
    rst = 1'b1;
    ch_addr = '0; ch_read = '0; ch_write = '0; ch_wdata = '0;
    bmem_ready = 1'b0; bmem_raddr = '0; bmem_rdata = '0; bmem_rvalid = 1'b0;
    repeat (3) tick();
    chk("rst_resp", ch_resp, 0);
    chk("rst_read", bmem_read, 0);
    chk("rst_write", bmem_write, 0);
    chk("rst_addr", bmem_addr, 0);
    chk("rst_wdata", bmem_wdata, 0);
    chk("rst_rdata", ch_rdata, 0);
    rst = 1'b0;
    tick();

    // Single write on ch1, ready held high.
    line = {64'h3, 64'h2, 64'h1, 64'h0};
    ch_addr[1*ADDR_W +: ADDR_W]  = 32'h200;
    ch_wdata[1*LINE_W +: LINE_W] = line;
    ch_write[1] = 1'b1;
    wr_txn(line, 32'h200, 3'b010, -1, 0);
    ch_write = '0;
    tick();
    chk("no_regrant_wr", bmem_write, 0);
    chk("no_regrant_rd", bmem_read, 0);

    // Read on ch0 with a two-cycle gap after beat 1.
    ch_addr[0*ADDR_W +: ADDR_W] = 32'h100;
    ch_read[0] = 1'b1;
    rd_txn(64'hA, 32'h100, 3'b001, 0, 1, 2);
    ch_read = '0;
    tick();
    chk("no_regrant_rd0", bmem_read, 0);

    // Ready low during the read command and in the middle of a write.
    ch_addr[1*ADDR_W +: ADDR_W] = 32'h300;
    ch_read[1] = 1'b1;
    rd_txn(64'h30, 32'h300, 3'b010, 3, -1, 0);
    ch_read = '0;
    tick();
    line = {64'h23, 64'h22, 64'h21, 64'h20};
    ch_addr[2*ADDR_W +: ADDR_W]  = 32'h500;
    ch_wdata[2*LINE_W +: LINE_W] = line;
    ch_write[2] = 1'b1;
    wr_txn(line, 32'h500, 3'b100, 2, 3);
    ch_write = '0;
    tick();

    // Read and write together on ch2 behaves as a write.
    line = {64'h43, 64'h42, 64'h41, 64'h40};
    ch_wdata[2*LINE_W +: LINE_W] = line;
    ch_write[2] = 1'b1;
    ch_read[2]  = 1'b1;
    wr_txn(line, 32'h500, 3'b100, -1, 0);
    ch_write = '0;
    ch_read  = '0;
    tick();
    chk("both_no_read", bmem_read, 0);

    // Reset in the middle of a write burst.
    line = {64'h53, 64'h52, 64'h51, 64'h50};
    ch_addr[0*ADDR_W +: ADDR_W]  = 32'h600;
    ch_wdata[0*LINE_W +: LINE_W] = line;
    ch_write[0] = 1'b1;
    bmem_ready  = 1'b1;
    tick();
    tick();
    tick();
    chk("abort_beat2", bmem_wdata, 64'h52);
    rst = 1'b1;
    #1;
    chk("abort_write", bmem_write, 0);
    chk("abort_wdata", bmem_wdata, 0);
    chk("abort_addr", bmem_addr, 0);
    chk("abort_read", bmem_read, 0);
    chk("abort_resp", ch_resp, 0);
    chk("abort_rdata", ch_rdata, 0);
    ch_write = '0;
    tick();
    rst = 1'b0;
    bmem_rvalid = 1'b1;
    bmem_rdata  = 64'h99;
    for (int i = 0; i < BEATS; i++) begin
      chk("stray_resp", ch_resp, 0);
      chk("stray_read", bmem_read, 0);
      tick();
    end
    bmem_rvalid = 1'b0;
    chk("stray_resp_end", ch_resp, 0);
    chk("stray_rdata", ch_rdata, 0);

    // All three channels request continuously.
    for (int c = 0; c < NUM_CH; c++) ch_addr[c*ADDR_W +: ADDR_W] = 32'h1000 + 32'(c) * 32'h40;
    ch_read = 3'b111;
    for (int n = 0; n < 4; n++) begin
`ifdef CLA_RR_ARB_EN
      exp_resp = 3'b001 << (n % 3);
      exp_addr = 32'h1000 + 32'(n % 3) * 32'h40;
`else
      exp_resp = 3'b001;
      exp_addr = 32'h1000;
`endif
      rd_txn(64'h100 * 64'(n + 1), exp_addr, exp_resp, 0, -1, 0);
    end
    ch_read = '0;
    tick();
    chk("arb_idle", bmem_read, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
